// File: rtl/hazard_control_pkg.sv
// rv32i_types: shared RV32I opcode/register types and the hazard controller state.
package rv32i_types;
    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;
    typedef logic [4:0] rv32i_reg;
    typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} hazard_state_t;
endpackage

// File: rtl/hazard_control_if.sv
// hazard_control_if: pipeline-side view of the hazard controller.
interface hazard_control_if;
    import rv32i_types::*;
    rv32i_reg    decode_rs1, decode_rs2, ex_rd;
    rv32i_opcode decode_opcode, ex_opcode;
    logic        br_taken, icache_read, icache_resp, dcache_read, dcache_write, dcache_resp;
    logic        cnt_clr, cnt_preload;
    logic [31:0] cnt_preload_val;
    logic        pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
    logic        if_id_flush, id_ex_flush;
    logic [31:0] stall_cnt, bubble_cnt, flush_cnt;
    modport master (
        output decode_rs1, decode_rs2, ex_rd, decode_opcode, ex_opcode,
        output br_taken, icache_read, icache_resp, dcache_read, dcache_write, dcache_resp,
        output cnt_clr, cnt_preload, cnt_preload_val,
        input  pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
        input  if_id_flush, id_ex_flush, stall_cnt, bubble_cnt, flush_cnt
    );
    modport slave (
        input  decode_rs1, decode_rs2, ex_rd, decode_opcode, ex_opcode,
        input  br_taken, icache_read, icache_resp, dcache_read, dcache_write, dcache_resp,
        input  cnt_clr, cnt_preload, cnt_preload_val,
        output pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
        output if_id_flush, id_ex_flush, stall_cnt, bubble_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_control_load_use_detect.sv
// load_use_detect: flags a decode instruction that reads the register a load in EX is still fetching.
module load_use_detect
    import rv32i_types::*;
(
    input  rv32i_reg    i_decode_rs1,
    input  rv32i_reg    i_decode_rs2,
    input  rv32i_reg    i_ex_rd,
    input  rv32i_opcode i_decode_opcode,
    input  rv32i_opcode i_ex_opcode,
    output logic        o_load_use
);
    logic w_rs2_used;
    assign w_rs2_used = i_decode_opcode inside {op_reg, op_store, op_br};
    assign o_load_use = (i_ex_opcode == op_load) && (i_ex_rd != '0) &&
                        ((i_decode_rs1 == i_ex_rd) || (w_rs2_used && (i_decode_rs2 == i_ex_rd)));
endmodule

// File: rtl/hazard_control.sv
// hazard_control: pipeline stall/flush/bubble control with event counters.
// Memory stalls dominate; a redirect seen while frozen is held until the pipeline moves.
module hazard_control
    import rv32i_types::*;
(
    input logic             clk,
    input logic             rst_n,
    hazard_control_if.slave hz
);
    hazard_state_t r_state, w_next_state;
    logic          r_flush_pending, w_next_flush_pending;
    logic [31:0]   r_stall_cnt, r_bubble_cnt, r_flush_cnt;
    logic          w_mem_busy, w_load_use, w_redirect;
    logic          w_inc_stall, w_inc_bubble, w_inc_flush;
    logic [4:0]    w_loads;
    logic [1:0]    w_flushes;

    assign w_mem_busy = (hz.icache_read & ~hz.icache_resp) |
                        ((hz.dcache_read | hz.dcache_write) & ~hz.dcache_resp);
    assign w_redirect = hz.br_taken | r_flush_pending;

    load_use_detect u_load_use_detect (
        .i_decode_rs1   (hz.decode_rs1),
        .i_decode_rs2   (hz.decode_rs2),
        .i_ex_rd        (hz.ex_rd),
        .i_decode_opcode(hz.decode_opcode),
        .i_ex_opcode    (hz.ex_opcode),
        .o_load_use     (w_load_use)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= RUN;
            r_flush_pending <= 1'b0;
        end else begin
            r_state         <= w_next_state;
            r_flush_pending <= w_next_flush_pending;
        end
    end

    always_comb begin
        w_next_state         = r_state;
        w_next_flush_pending = r_flush_pending;
        w_loads              = 5'b11111;
        w_flushes            = 2'b00;
        w_inc_stall          = 1'b0;
        w_inc_bubble         = 1'b0;
        w_inc_flush          = 1'b0;
        if (w_mem_busy) begin
            w_next_state         = MEM_WAIT;
            w_next_flush_pending = r_flush_pending | hz.br_taken;
            w_loads              = 5'b00000;
            w_inc_stall          = 1'b1;
        end else begin
            w_next_state = RUN;
            if (w_redirect) begin
                w_next_flush_pending = 1'b0;
                w_flushes            = 2'b11;
                w_inc_flush          = 1'b1;
            end else if (w_load_use) begin
                w_loads      = 5'b00111;
                w_flushes    = 2'b01;
                w_inc_bubble = 1'b1;
            end
        end
    end

    // Clear beats preload, preload beats any same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else if (hz.cnt_clr) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else if (hz.cnt_preload) begin
            r_stall_cnt  <= hz.cnt_preload_val;
            r_bubble_cnt <= hz.cnt_preload_val;
            r_flush_cnt  <= hz.cnt_preload_val;
        end else begin
            r_stall_cnt  <= r_stall_cnt + 32'(w_inc_stall);
            r_bubble_cnt <= r_bubble_cnt + 32'(w_inc_bubble);
            r_flush_cnt  <= r_flush_cnt + 32'(w_inc_flush);
        end
    end

    assign hz.pc_load     = rst_n & w_loads[4];
    assign hz.if_id_load  = rst_n & w_loads[3];
    assign hz.id_ex_load  = rst_n & w_loads[2];
    assign hz.ex_mem_load = rst_n & w_loads[1];
    assign hz.mem_wb_load = rst_n & w_loads[0];
    assign hz.if_id_flush = ~rst_n | w_flushes[1];
    assign hz.id_ex_flush = ~rst_n | w_flushes[0];
    assign hz.stall_cnt   = r_stall_cnt;
    assign hz.bubble_cnt  = r_bubble_cnt;
    assign hz.flush_cnt   = r_flush_cnt;
endmodule

// File: doc/hazard_control.md
HAZARD_CONTROL -- requirements
Module: hazard_control

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port decode_rs1/decode_rs2, input, rv32i_reg each: source registers of the instruction in decode.
REQ-004 SHALL have port decode_opcode, input, rv32i_opcode: opcode of the instruction in decode.
REQ-005 SHALL have ports ex_rd (rv32i_reg) and ex_opcode (rv32i_opcode), input: destination register and opcode of the instruction in execute.
REQ-006 SHALL have ports br_taken, icache_read, icache_resp, dcache_read, dcache_write, dcache_resp, cnt_clr, input, 1 bit each: EX branch/jump redirect, cache request and response strobes, counter clear.
REQ-007 SHALL have ports pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load, output, 1 bit each: pipeline register enables.
REQ-008 SHALL have ports if_id_flush, id_ex_flush, output, 1 bit each: load a NOP into the IF/ID or ID/EX register.
REQ-009 SHALL have ports stall_cnt, bubble_cnt, flush_cnt, output, 32 bits each: event counters.

Function
REQ-010 SHALL compute mem_busy = (icache_read and not icache_resp) or ((dcache_read or dcache_write) and not dcache_resp).
REQ-011 SHALL compute load_use = ex_opcode==op_load, ex_rd!=0, and (decode_rs1==ex_rd, or decode_rs2==ex_rd with decode_opcode in {op_reg, op_store, op_br}).
REQ-012 SHALL resolve each cycle in fixed priority: mem_busy, then redirect (br_taken or flush_pending), then load_use, then normal.
REQ-013 SHALL on mem_busy: drive all five load enables 0 and both flushes 0; next state MEM_WAIT; increment stall_cnt.
REQ-014 SHALL on mem_busy with br_taken: set flush_pending, so the redirect is not lost while frozen.
REQ-015 SHALL on redirect without mem_busy: drive all loads 1 and if_id_flush = id_ex_flush = 1; clear flush_pending; increment flush_cnt exactly once.
REQ-016 SHALL on load_use only: drive pc_load = if_id_load = 0, id_ex_load = 1 with id_ex_flush = 1, ex_mem_load = mem_wb_load = 1; increment bubble_cnt. Exactly one bubble results, because the load advances.
REQ-017 SHALL in normal case: drive all loads 1 and both flushes 0.
REQ-018 SHALL use states RUN and MEM_WAIT:
- RUN -> MEM_WAIT on mem_busy.
- MEM_WAIT -> RUN on the first cycle with mem_busy = 0, processing that cycle by REQ-012.
REQ-019 SHALL derive outputs combinationally from current inputs, state and flush_pending, with zero-cycle latency.
REQ-020 SHALL make counters wrap modulo 2^32.
REQ-021 SHALL apply cnt_clr synchronously: counters read 0 next cycle; cnt_clr takes priority over any same-cycle increment.
REQ-022 SHALL treat simultaneous load_use and br_taken as redirect only: no bubble, bubble_cnt unchanged.

Reset
REQ-023 SHALL on rst_n low, immediately: state = RUN, flush_pending = 0, all counters = 0.
REQ-024 SHALL during reset drive all load enables 0 and both flushes 1, so pipeline registers hold NOPs.
REQ-025 SHALL, if reset asserts mid-MEM_WAIT, discard the pending redirect; first cycle after release behaves per REQ-012 from RUN.

Structure
REQ-026 SHALL place the hazard_state_t enum (RUN, MEM_WAIT) in rv32i_types beside rv32i_opcode and rv32i_reg.
REQ-027 SHALL implement REQ-011 in one combinational sub-module, load_use_detect.

Verification
REQ-028 SHALL cover load-use:
- Stimulus: ex_opcode=op_load, ex_rd=5, decode_opcode=op_reg, decode_rs2=5.
- Response: pc_load=0, if_id_load=0, id_ex_flush=1 for one cycle; bubble_cnt=1.
REQ-029 SHALL cover x0 and I-type exclusions:
- Stimulus: load with ex_rd=0; separately, op_imm decode_rs2=ex_rd=7.
- Response: no bubble either case.
REQ-030 SHALL cover D-cache miss with branch:
- Stimulus: dcache_read=1, dcache_resp=0 for 4 cycles; br_taken=1 in cycle 2.
- Response: loads 0 for 4 cycles; stall_cnt=4; on cycle 5, both flushes=1 once; flush_cnt=1.
REQ-031 SHALL cover counter wrap:
- Stimulus: preload path forces stall_cnt to 0xFFFF_FFFF, then one mem_busy cycle.
- Response: stall_cnt=0.
- Stimulus: cnt_clr with a simultaneous bubble.
- Response: bubble_cnt=0.
REQ-032 SHALL cover asynchronous reset:
- Stimulus: rst_n=0 mid-MEM_WAIT with flush_pending=1.
- Response: counters 0 immediately, without a clock edge; after release and mem_busy=0, no flush issued.
